regfile_wr_arbiter: RTL and testbench

Sequencer and arbiter for the single write port of the 8x16b bypassed register file. After reset it walks every register and writes a known value, so no architectural register is ever read uninitialised. It then shares the one write port between two writeback requesters (A: ALU writeback, B: memory/load writeback) using valid/ready handshakes and round-robin arbitration. It sits between the writeback stage and the register file's writeRegSel/writeData/writeEn inputs.

---
 rtl/regfile_wr_arbiter.sv | 60 ++++++
 tb/tb_regfile_wr_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: register-file write port sequencer; sweeps INIT_VAL into every register after reset, then round-robin arbitrates requesters a/b (valid/sel/data/ready) onto registered writeEn/writeRegSel/writeData, with init_done flagging the end of the sweep
module regfile_wr_arbiter #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W = 3,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [SEL_W-1:0]  a_sel,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [SEL_W-1:0]  b_sel,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic [SEL_W-1:0]  writeRegSel,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEn,
  output logic              init_done
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [SEL_W:0] last_cnt = (SEL_W+1)'(NUM_REGS - 1);
  state_t state;
  logic [SEL_W:0] cnt;
  logic last_b;
  logic run;
  assign run = state == RUN;
  assign a_ready = run & a_valid & (~b_valid | last_b);
  assign b_ready = run & b_valid & ~a_ready;
  assign init_done = run;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      last_b <= 1'b1;
      writeEn <= 1'b0;
      writeRegSel <= '0;
      writeData <= '0;
    end else if (!run) begin
      writeEn <= 1'b1;
      writeRegSel <= cnt[SEL_W-1:0];
      writeData <= INIT_VAL;
      cnt <= cnt + 1'b1;
      if (cnt == last_cnt) state <= RUN;
    end else begin
      writeEn <= a_ready | b_ready;
      if (a_ready) begin
        writeRegSel <= a_sel;
        writeData <= a_data;
        last_b <= 1'b0;
      end else if (b_ready) begin
        writeRegSel <= b_sel;
        writeData <= b_data;
        last_b <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed bench with a cycle-level behavioural model checked every cycle plus literal expectations
module tb_regfile_wr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [2:0] a_sel = '0, b_sel = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, writeEn, init_done;
  logic [2:0] writeRegSel;
  logic [15:0] writeData;
  logic [15:0] mem [8];
  int errors = 0;
  int checks = 0;
  int m_inits;
  bit m_last_b;
  bit m_we;
  int m_sel;
  int m_data;

  regfile_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_data(b_data), .b_ready(b_ready),
    .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (writeEn) mem[writeRegSel] <= writeData;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (!rst_n || m_inits < 8) return 0;
    if (a_valid && b_valid) return m_last_b ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_inits = 0;
    m_last_b = 1'b1;
    m_we = 1'b0;
    m_sel = 0;
    m_data = 0;
  endtask

  task automatic model_step();
    int w;
    if (!rst_n) return;
    w = winner();
    if (m_inits < 8) begin
      m_we = 1'b1;
      m_sel = m_inits;
      m_data = 0;
      m_inits++;
    end else if (w == 1) begin
      m_we = 1'b1;
      m_sel = a_sel;
      m_data = a_data;
      m_last_b = 1'b0;
    end else if (w == 2) begin
      m_we = 1'b1;
      m_sel = b_sel;
      m_data = b_data;
      m_last_b = 1'b1;
    end else m_we = 1'b0;
  endtask

  task automatic compare_all();
    check("model_we", writeEn, m_we);
    check("model_sel", writeRegSel, m_sel);
    check("model_data", writeData, m_data);
    check("model_init_done", init_done, m_inits == 8);
    check("model_a_ready", a_ready, winner() == 1);
    check("model_b_ready", b_ready, winner() == 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic expect_write(input string name, input int sel, input int data);
    check({name, "_we"}, writeEn, 1);
    check({name, "_sel"}, writeRegSel, sel);
    check({name, "_data"}, writeData, data);
  endtask

  task automatic init_sweep(input string name);
    for (int e = 1; e <= 8; e++) begin
      tick();
      expect_write(name, e - 1, 0);
      check({name, "_a_ready"}, a_ready, e == 8 ? 1 : 0);
      check({name, "_init_done"}, init_done, e == 8 ? 1 : 0);
    end
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) tick();
    check("rst_we", writeEn, 0);
    check("rst_sel", writeRegSel, 0);
    check("rst_data", writeData, 0);
    check("rst_init_done", init_done, 0);
    a_valid = 1'b1; a_sel = 3'd3; a_data = 16'hBEEF;
    rst_n = 1'b1;
    init_sweep("init");
    tick();
    expect_write("single", 3, 16'hBEEF);
    a_valid = 1'b0;
    tick();
    check("single_idle_we", writeEn, 0);
    check("single_idle_sel", writeRegSel, 3);
    b_valid = 1'b1; b_sel = 3'd6;
    for (int k = 0; k < 3; k++) begin
      b_data = 16'h6000 + 16'(k);
      #1 check("stall_b_ready", b_ready, 1);
      tick();
      expect_write("stall", 6, 16'h6000 + k);
    end
    b_valid = 1'b0;
    tick();
    check("hold_we", writeEn, 0);
    check("hold_sel", writeRegSel, 6);
    check("hold_data", writeData, 16'h6002);
    a_valid = 1'b1; a_sel = 3'd1; a_data = 16'h1111;
    b_valid = 1'b1; b_sel = 3'd2; b_data = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) expect_write("rr_a", 1, 16'h1111);
      else expect_write("rr_b", 2, 16'h2222);
    end
    a_sel = 3'd5; a_data = 16'hAAAA;
    b_sel = 3'd5; b_data = 16'hBBBB;
    #1 check("coll_a_ready", a_ready, 1);
    check("coll_b_ready", b_ready, 0);
    tick();
    expect_write("coll_first", 5, 16'hAAAA);
    a_valid = 1'b0;
    tick();
    expect_write("coll_second", 5, 16'hBBBB);
    b_valid = 1'b0;
    tick();
    check("coll_r5", mem[5], 16'hBBBB);
    a_valid = 1'b1; a_sel = 3'd7; a_data = 16'h7777;
    tick();
    expect_write("a_alone", 7, 16'h7777);
    a_sel = 3'd4; a_data = 16'h4444;
    #2 check("midrst_a_ready", a_ready, 1);
    rst_n = 1'b0;
    model_reset();
    #1 check("midrst_we", writeEn, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_a_ready_low", a_ready, 0);
    a_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    a_valid = 1'b1; a_sel = 3'd0; a_data = 16'h0A0A;
    b_valid = 1'b1; b_sel = 3'd0; b_data = 16'h0B0B;
    init_sweep("reinit");
    check("reinit_r4", mem[4], 0);
    tick();
    expect_write("first_tie_a", 0, 16'h0A0A);
    a_valid = 1'b0;
    tick();
    expect_write("first_tie_b", 0, 16'h0B0B);
    b_valid = 1'b0;
    tick();
    check("end_we", writeEn, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
